// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl
//   Idle-detect controller driving the enable of a clock_gate cell for one
//   gated clock domain. Counts idle cycles across NUM_REQ requesters, runs a
//   request/acknowledge handshake before removing the clock, and sequences a
//   fixed wake-up delay before declaring the domain ready again.
//
// Ports
//   clk_i          free-running clock, rising edge
//   rst_i          synchronous active-high reset
//   busy_i         per-requester activity (any bit high = not idle)
//   wake_i         per-requester wake request
//   force_on_i     override: high = never gate
//   gate_ack_i     gated domain agrees to lose its clock (sampled in REQ only)
//   enable_o       to clock_gate enable (high = clock runs)
//   gate_req_o     request to gated domain to quiesce
//   ready_o        gated clock running and stable
//   state_o        current FSM state, for debug
//   gated_cycles_o cycles spent gated (statistics build only, else 0)
//
// Build option
//   CLK_GATE_STATS_EN : when defined, gated_cycles_o is a saturating 32-bit
//                       count of GATED cycles; otherwise it is tied to zero.

module clock_gate_ctrl #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] busy_i,
    input  logic [NUM_REQ-1:0] wake_i,
    input  logic               force_on_i,
    input  logic               gate_ack_i,
    output logic               enable_o,
    output logic               gate_req_o,
    output logic               ready_o,
    output logic [2:0]         state_o,
    output logic [31:0]        gated_cycles_o
);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_REQ   = 3'd2,
        ST_GATED = 3'd3,
        ST_WAKE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             act, wk;

    assign act = (|busy_i) | (|wake_i) | force_on_i;
    assign wk  = (|wake_i) | force_on_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (!act) begin
                    state_d = ST_IDLE;
                    cnt_d   = IDLE_LOAD;
                end
            end
            ST_IDLE: begin
                if (act) begin
                    state_d = ST_RUN;
                end else if (cnt_q == '0) begin
                    state_d = ST_REQ;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_REQ: begin
                // Activity takes priority over a same-cycle acknowledge.
                if (act) begin
                    state_d = ST_RUN;
                end else if (gate_ack_i) begin
                    state_d = ST_GATED;
                end
            end
            ST_GATED: begin
                // busy_i is meaningless here: the domain has no clock.
                if (wk) begin
                    state_d = ST_WAKE;
                    cnt_d   = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Moore outputs; unknown encodings keep the clock running.
    always_comb begin
        enable_o   = 1'b1;
        ready_o    = 1'b1;
        gate_req_o = 1'b0;
        case (state_q)
            ST_REQ:   gate_req_o = 1'b1;
            ST_GATED: begin
                enable_o = 1'b0;
                ready_o  = 1'b0;
            end
            ST_WAKE:  ready_o = 1'b0;
            default:  ;
        endcase
    end

    assign state_o = state_q;

`ifdef CLK_GATE_STATS_EN
    logic [31:0] gated_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gated_cnt_q <= '0;
        end else if (state_q == ST_GATED && gated_cnt_q != '1) begin
            gated_cnt_q <= gated_cnt_q + 32'd1;
        end
    end

    assign gated_cycles_o = gated_cnt_q;
`else
    assign gated_cycles_o = '0;
`endif

endmodule

// File: doc/clock_gate_ctrl.md
Name: clock_gate_ctrl

Overview:
Idle-detect controller that drives the enable input of a clock_gate cell for one gated clock domain. It watches activity/wake requests from NUM_REQ requesters and counts idle cycles. It runs a request/acknowledge handshake with the gated domain before removing the clock, and sequences a fixed wake-up delay before declaring the domain ready. The block sits in the free-running clk_i domain, next to the clock_gate instance it controls.

Parameters:
NUM_REQ, 4, number of requesters; width of busy_i/wake_i; legal range 1..16
IDLE_CYCLES, 16, consecutive idle cycles in RUN/IDLE before a gate request; legal range 1..2^CNT_W
WAKE_CYCLES, 2, cycles enable_o is high before ready_o asserts after wake; legal range 1..2^CNT_W
CNT_W, 8, width of the shared down-counter

Ports:
clk_i  input  1  free-running clock; all logic on rising edge
rst_i  input  1  synchronous, active-high reset
busy_i  input  NUM_REQ  per-requester activity in the gated domain; any bit high = not idle
wake_i  input  NUM_REQ  per-requester wake request; valid in every state
force_on_i  input  1  debug/software override; high = never gate
gate_ack_i  input  1  gated domain agrees to lose its clock; sampled only in REQ
enable_o  output  1  to clock_gate enable_i; high = clock runs
gate_req_o  output  1  request to gated domain to quiesce
ready_o  output  1  gated clock running and stable
state_o  output  3  current FSM state encoding, for debug
gated_cycles_o  output  32  optional statistics (see Optional Feature)

Behaviour:
- One clock domain (clk_i). Reset is synchronous and active-high (rst_i). Moore outputs decoded from the registered state; no combinational input-to-output paths.
- Definitions: act = |busy_i | |wake_i | force_on_i. wk = |wake_i | force_on_i.
- States and encodings: RUN=0, IDLE=1, REQ=2, GATED=3, WAKE=4. Other encodings recover to RUN on the next cycle.
- Outputs by state:
  - RUN and IDLE: enable_o=1, ready_o=1, gate_req_o=0.
  - REQ: enable_o=1, ready_o=1, gate_req_o=1.
  - GATED: enable_o=0, ready_o=0, gate_req_o=0.
  - WAKE: enable_o=1, ready_o=0, gate_req_o=0.
- Reset values: state RUN, counter 0, enable_o=1, ready_o=1, gate_req_o=0, state_o=0, gated_cycles_o=0. Reset asserted in any state, including GATED or REQ, returns to RUN on the next edge, so the clock is restored.
- Transitions:
  - RUN: if !act, go to IDLE and load counter = IDLE_CYCLES-1. Otherwise stay.
  - IDLE: if act, go to RUN. Else if counter==0, go to REQ. Else decrement.
  - REQ: if act, go to RUN and drop gate_req_o. This applies even when gate_ack_i is high in the same cycle; activity wins. Else if gate_ack_i, go to GATED. Else hold; there is no timeout.
  - GATED: busy_i is ignored (the domain is unclocked). If wk, go to WAKE and load counter = WAKE_CYCLES-1.
  - WAKE: wake/busy inputs are ignored. If counter==0, go to RUN. Else decrement.
- Latency:
  - From a cycle with act low (in RUN), gate_req_o rises IDLE_CYCLES+1 edges later. Example: IDLE_CYCLES=16, idle from cycle 0 → gate_req_o high at cycle 17.
  - From gate_ack_i sampled high in REQ, enable_o falls on the next edge.
  - From wake sampled in GATED, enable_o rises on the next edge and ready_o rises WAKE_CYCLES edges after that.
- gate_ack_i is ignored outside REQ.
- force_on_i held high keeps the FSM in RUN. Once asserted in GATED, it behaves as a wake.

Optional Feature:
Macro CLK_GATE_STATS_EN.
- Defined: gated_cycles_o is a 32-bit counter.
  - Increments every cycle the state is GATED.
  - Saturates at 0xFFFFFFFF (no wrap).
  - Cleared by rst_i.
- Not defined: gated_cycles_o is tied to 0 and no counter logic is synthesized. The port list is identical in both builds.

Test Plan:
1. Reset with busy_i=4'b0001 then busy_i=0 at cycle 0, IDLE_CYCLES=16 → enable_o=1 throughout; gate_req_o rises at cycle 17; hold gate_ack_i=0 → gate_req_o stays high, enable_o stays 1.
2. In REQ, pulse gate_ack_i=1 → next edge state_o=3, enable_o=0, ready_o=0. Then wake_i=4'b0100 for one cycle, WAKE_CYCLES=2 → enable_o=1 one edge later, ready_o=1 two edges after that, state_o=0.
3. Idle count at 10 of 16 when busy_i=4'b1000 pulses one cycle → return to RUN. The full 16-cycle count restarts and gate_req_o rises 17 cycles after busy drops.
4. In REQ, assert gate_ack_i=1 and wake_i=4'b0001 in the same cycle → state RUN, enable_o stays 1, gate_req_o=0.
5. force_on_i=1 held 100 cycles with busy_i=0 → state stays RUN, gate_req_o never asserts. Then assert rst_i for one cycle while in GATED → next edge enable_o=1, ready_o=1, state_o=0.
6. With CLK_GATE_STATS_EN defined, hold GATED for 50 cycles → gated_cycles_o=50. Without the macro → gated_cycles_o=0.
